// File: rtl/render_pkg.sv
// Shared render types: coordinate width, palette indices and loader state.
package render_pkg;

  localparam int COORD_WIDTH = 32;

  localparam logic [3:0] BLACK   = 4'd0;
  localparam logic [3:0] BLUE    = 4'd1;
  localparam logic [3:0] GREEN   = 4'd2;
  localparam logic [3:0] CYAN    = 4'd3;
  localparam logic [3:0] RED     = 4'd4;
  localparam logic [3:0] MAGENTA = 4'd5;
  localparam logic [3:0] BROWN   = 4'd6;
  localparam logic [3:0] LGRAY   = 4'd7;
  localparam logic [3:0] DGRAY   = 4'd8;
  localparam logic [3:0] LBLUE   = 4'd9;

  typedef enum logic {LOADING, COMMITTED} loader_state_t;

endpackage

// File: rtl/polygon_bank.sv
// One bank of the polygon table: vertex/color/side storage plus a committed count.
module polygon_bank #(
  parameter int NV = 8,
  parameter int NP = 4,
  parameter int CW = 32
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       wr_en,
  input  logic [$clog2(NP)-1:0]      wr_poly,
  input  logic [$clog2(NV)-1:0]      wr_vtx,
  input  logic signed [CW-1:0]       wr_x,
  input  logic signed [CW-1:0]       wr_y,
  input  logic                       color_en,
  input  logic [3:0]                 wr_color,
  input  logic                       sides_en,
  input  logic [$clog2(NV+1)-1:0]    wr_sides,
  input  logic                       count_en,
  input  logic [$clog2(NP+1)-1:0]    wr_count,
  input  logic                       clear,
  output logic [NP*NV*CW-1:0]        xs,
  output logic [NP*NV*CW-1:0]        ys,
  output logic [NP*$clog2(NV+1)-1:0] num_sides,
  output logic [NP*4-1:0]            colors,
  output logic [$clog2(NP+1)-1:0]    count
);
  localparam int SW   = $clog2(NV + 1);
  localparam int CNTW = $clog2(NP + 1);

  logic [CW-1:0]   x_reg     [NP][NV];
  logic [CW-1:0]   y_reg     [NP][NV];
  logic [SW-1:0]   sides_reg [NP];
  logic [3:0]      color_reg [NP];
  logic [CNTW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int p = 0; p < NP; p++) begin
        sides_reg[p] <= '0;
        color_reg[p] <= '0;
        for (int v = 0; v < NV; v++) begin
          x_reg[p][v] <= '0;
          y_reg[p][v] <= '0;
        end
      end
      count_reg <= '0;
    end else begin
      if (wr_en) begin
        x_reg[wr_poly][wr_vtx] <= wr_x;
        y_reg[wr_poly][wr_vtx] <= wr_y;
      end
      if (color_en) color_reg[wr_poly] <= wr_color;
      if (sides_en) sides_reg[wr_poly] <= wr_sides;
      if (clear)         count_reg <= '0;
      else if (count_en) count_reg <= wr_count;
    end
  end

  // Polygon-major flattening: entry (p, v) lives at word p*NV + v.
  for (genvar gi = 0; gi < NP; gi++) begin : g_poly
    assign num_sides[gi*SW +: SW] = sides_reg[gi];
    assign colors[gi*4 +: 4]      = color_reg[gi];
    for (genvar gj = 0; gj < NV; gj++) begin : g_vtx
      assign xs[(gi*NV + gj)*CW +: CW] = x_reg[gi][gj];
      assign ys[(gi*NV + gj)*CW +: CW] = y_reg[gi][gj];
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/polygon_list_loader.sv
// Assembles streamed vertices into a back polygon bank; swaps banks at frame boundaries.
module polygon_list_loader #(
  parameter int MAX_NUM_VERTICES       = 8,
  parameter int MAX_POLYGONS_ON_SCREEN = 4,
  parameter int COORD_WIDTH            = render_pkg::COORD_WIDTH
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     vtx_valid_in,
  output logic                     vtx_ready_out,
  input  logic signed [COORD_WIDTH-1:0] vtx_x_in,
  input  logic signed [COORD_WIDTH-1:0] vtx_y_in,
  input  logic [3:0]               vtx_color_in,
  input  logic                     vtx_last_in,
  input  logic                     list_done_in,
  input  logic                     new_frame_in,
  output logic [MAX_POLYGONS_ON_SCREEN*MAX_NUM_VERTICES*COORD_WIDTH-1:0] xs_out,
  output logic [MAX_POLYGONS_ON_SCREEN*MAX_NUM_VERTICES*COORD_WIDTH-1:0] ys_out,
  output logic [MAX_POLYGONS_ON_SCREEN*$clog2(MAX_NUM_VERTICES+1)-1:0]   num_sides_out,
  output logic [MAX_POLYGONS_ON_SCREEN*4-1:0]                             colors_out,
  output logic [$clog2(MAX_POLYGONS_ON_SCREEN+1)-1:0]                     polygons_on_screen_out,
  output logic                     overflow_out,
  output logic [7:0]               frames_missed_out
);
  import render_pkg::*;

  localparam int NV   = MAX_NUM_VERTICES;
  localparam int NP   = MAX_POLYGONS_ON_SCREEN;
  localparam int SW   = $clog2(NV + 1);
  localparam int CNTW = $clog2(NP + 1);
  localparam int TW   = NP * NV * COORD_WIDTH;
  localparam logic [SW-1:0]   NV_S  = SW'(NV);
  localparam logic [SW-1:0]   ONE_V = SW'(1);
  localparam logic [SW-1:0]   MIN_V = SW'(3);
  localparam logic [CNTW-1:0] NP_C  = CNTW'(NP);
  localparam logic [CNTW-1:0] ONE_P = CNTW'(1);

  loader_state_t   state_reg, state_next;
  logic            sel_reg, sel_next;
  logic [CNTW-1:0] poly_idx_reg, poly_idx_next;
  logic [SW-1:0]   vtx_idx_reg, vtx_idx_next;
  logic            overflow_reg, overflow_next;
  logic [7:0]      missed_reg, missed_next;

  logic            beat, wr_en, color_en, sides_en, count_en, clear_en;
  logic [SW-1:0]   vtx_cnt, wr_sides;
  logic [CNTW-1:0] wr_count;

  assign vtx_ready_out = (state_reg == LOADING) && !rst_in;
  assign beat          = vtx_valid_in && vtx_ready_out;

  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    poly_idx_next = poly_idx_reg;
    vtx_idx_next  = vtx_idx_reg;
    overflow_next = overflow_reg;
    missed_next   = missed_reg;
    wr_en    = 1'b0;
    color_en = 1'b0;
    sides_en = 1'b0;
    count_en = 1'b0;
    clear_en = 1'b0;
    vtx_cnt  = '0;
    wr_sides = '0;
    wr_count = '0;
    if (state_reg == LOADING) begin
      if (beat) begin
        if (poly_idx_reg == NP_C) begin
          overflow_next = 1'b1;
        end else begin
          if (vtx_idx_reg < NV_S) begin
            wr_en        = 1'b1;
            color_en     = (vtx_idx_reg == '0);
            vtx_idx_next = vtx_idx_reg + ONE_V;
          end else begin
            overflow_next = 1'b1;
          end
          if (vtx_last_in) begin
            // vtx_idx saturates at NV, so this is already min(count, NV).
            vtx_cnt      = (vtx_idx_reg == NV_S) ? NV_S : vtx_idx_reg + ONE_V;
            vtx_idx_next = '0;
            if (vtx_cnt >= MIN_V) begin
              sides_en      = 1'b1;
              wr_sides      = vtx_cnt;
              poly_idx_next = poly_idx_reg + ONE_P;
            end
          end
        end
      end
      if (list_done_in) begin
        count_en     = 1'b1;
        wr_count     = poly_idx_next;
        vtx_idx_next = '0;
        state_next   = COMMITTED;
      end else if (new_frame_in && missed_reg != 8'hFF) begin
        missed_next = missed_reg + 8'd1;
      end
    end
    // A frame boundary after (or together with) a commit swaps the banks.
    if (new_frame_in && (state_reg == COMMITTED || list_done_in)) begin
      sel_next      = ~sel_reg;
      clear_en      = 1'b1;
      poly_idx_next = '0;
      vtx_idx_next  = '0;
      state_next    = LOADING;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg    <= LOADING;
      sel_reg      <= 1'b0;
      poly_idx_reg <= '0;
      vtx_idx_reg  <= '0;
      overflow_reg <= 1'b0;
      missed_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      poly_idx_reg <= poly_idx_next;
      vtx_idx_reg  <= vtx_idx_next;
      overflow_reg <= overflow_next;
      missed_reg   <= missed_next;
    end
  end

  logic [TW-1:0]      bank_xs     [2];
  logic [TW-1:0]      bank_ys     [2];
  logic [NP*SW-1:0]   bank_sides  [2];
  logic [NP*4-1:0]    bank_colors [2];
  logic [CNTW-1:0]    bank_count  [2];

  // Bank sel_reg is the front; the other bank receives writes and commits.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic is_back;
    assign is_back = (sel_reg != 1'(gi));
    polygon_bank #(.NV(NV), .NP(NP), .CW(COORD_WIDTH)) u_bank (
      .clk       (clk_in),
      .srst      (rst_in),
      .wr_en     (wr_en && is_back),
      .wr_poly   (poly_idx_reg[$clog2(NP)-1:0]),
      .wr_vtx    (vtx_idx_reg[$clog2(NV)-1:0]),
      .wr_x      (vtx_x_in),
      .wr_y      (vtx_y_in),
      .color_en  (color_en && is_back),
      .wr_color  (vtx_color_in),
      .sides_en  (sides_en && is_back),
      .wr_sides  (wr_sides),
      .count_en  (count_en && is_back),
      .wr_count  (wr_count),
      .clear     (clear_en && !is_back),
      .xs        (bank_xs[gi]),
      .ys        (bank_ys[gi]),
      .num_sides (bank_sides[gi]),
      .colors    (bank_colors[gi]),
      .count     (bank_count[gi])
    );
  end

  assign xs_out                 = bank_xs[sel_reg];
  assign ys_out                 = bank_ys[sel_reg];
  assign num_sides_out          = bank_sides[sel_reg];
  assign colors_out             = bank_colors[sel_reg];
  assign polygons_on_screen_out = rst_in ? '0 : bank_count[sel_reg];
  assign overflow_out           = overflow_reg;
  assign frames_missed_out      = missed_reg;

endmodule
